ascon_perm_iter: RTL and testbench

ASCON_PERM_ITER -- requirements
Module: ascon_perm_iter

---
 rtl/ascon_perm_iter.sv | 130 +++++++++++++
 tb/tb_ascon_perm_iter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_iter.sv
// Iterative ASCON permutation: one full round per clock, with R = min(rounds_i, 12).
// Valid/ready load and unload handshakes around an IDLE/RUN/DONE controller.
module ascon_perm_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [319:0] S_i,
    input  logic [3:0]   rounds_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [319:0] S_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [319:0]  s_q;
    logic [319:0]  s_round;
    logic [3:0]    cnt_q;
    logic [3:0]    r_q;
    logic [3:0]    r_eff;
    logic [3:0]    cnt_next;
    logic [3:0]    idx;
    logic [7:0]    rc;
    logic [63:0]   x0, x1, x2, x3, x4;
    logic [63:0]   b0, b1, b2, b3, b4;
    logic [63:0]   c0, c1, c2, c3, c4;
    logic [63:0]   d0, d1, d2, d3, d4;

    function automatic logic [63:0] lin(input logic [63:0] v, input int unsigned a,
                                        input int unsigned b);
        logic [127:0] ra;
        logic [127:0] rb;
        ra = {v, v} >> a;
        rb = {v, v} >> b;
        return v ^ ra[63:0] ^ rb[63:0];
    endfunction

    assign r_eff    = (rounds_i > 4'd12) ? 4'd12 : rounds_i;
    assign cnt_next = cnt_q + 4'd1;
    // Constant index starts at 12-R so shortened permutations use the tail constants.
    assign idx      = 4'd12 - r_q + cnt_q;
    assign rc       = {4'd15 - idx, idx};

    always_comb begin
        x0 = s_q[319:256];
        x1 = s_q[255:192];
        x2 = s_q[191:128] ^ {56'd0, rc};
        x3 = s_q[127:64];
        x4 = s_q[63:0];

        b0 = x0 ^ x4;
        b1 = x1;
        b2 = x2 ^ x1;
        b3 = x3;
        b4 = x4 ^ x3;

        c0 = b0 ^ (~b1 & b2);
        c1 = b1 ^ (~b2 & b3);
        c2 = b2 ^ (~b3 & b4);
        c3 = b3 ^ (~b4 & b0);
        c4 = b4 ^ (~b0 & b1);

        d0 = c0 ^ c4;
        d1 = c1 ^ c0;
        d2 = ~c2;
        d3 = c3 ^ c2;
        d4 = c4;

        s_round = {lin(d0, 19, 28), lin(d1, 61, 39), lin(d2, 1, 6),
                   lin(d3, 10, 17), lin(d4, 7, 41)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            s_q         <= '0;
            cnt_q       <= '0;
            r_q         <= '0;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        s_q        <= S_i;
                        cnt_q      <= '0;
                        r_q        <= r_eff;
                        in_ready_o <= 1'b0;
                        if (r_eff == 4'd0) begin
                            state       <= DONE;
                            out_valid_o <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    s_q   <= s_round;
                    cnt_q <= cnt_next;
                    if (cnt_next == r_q) begin
                        state       <= DONE;
                        busy_o      <= 1'b0;
                        out_valid_o <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state       <= IDLE;
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

    assign S_o = s_q;

endmodule

// File: tb/tb_ascon_perm_iter.sv
// Bench for ascon_perm_iter: table-driven S-box reference model, directed and random scenarios.
// Latency is counted in clock edges after the load edge; R=0 results are visible right after the load edge.
module tb_ascon_perm_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [319:0] S_i;
    logic [3:0]   rounds_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [319:0] S_o;
    logic         busy_o;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [4:0] sbox [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                              5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                              5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                              5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    ascon_perm_iter dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .S_i(S_i), .rounds_i(rounds_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .S_o(S_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Column-wise table lookup rather than the bitsliced boolean form.
    function automatic logic [319:0] model_perm(input logic [319:0] s, input int unsigned rounds);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col;
        logic [4:0]  o;
        int unsigned r;
        int unsigned ci;
        r = (rounds > 12) ? 12 : rounds;
        for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
        for (int unsigned k = 0; k < r; k++) begin
            ci = 12 - r + k;
            x[2][7:0] = x[2][7:0] ^ 8'(((15 - ci) << 4) | ci);
            for (int j = 0; j < 64; j++) begin
                col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                o = sbox[col];
                for (int w = 0; w < 5; w++) y[w][j] = o[4 - w];
            end
            x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
            x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
            x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
            x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
            x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Load then scramble inputs so any post-load sampling shows up as a wrong result.
    task automatic do_load(input logic [319:0] s, input logic [3:0] r);
        @(negedge clk);
        S_i = s; rounds_i = r; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        S_i = rand320();
        rounds_i = 4'($urandom);
    endtask

    task automatic wait_done(output int unsigned lat);
        lat = 0;
        while (out_valid_o !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk); out_ready_i = 1'b1;
        @(posedge clk); #1; out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0; S_i = '1; rounds_i = 4'd12;
        #12;
        checks++;
        if ({in_ready_o, out_valid_o, busy_o} !== 3'b100) begin
            errors++; $display("FAIL reset_flags: got %b expected 100", {in_ready_o, out_valid_o, busy_o});
        end
        checks++;
        if (S_o !== '0) begin errors++; $display("FAIL reset_state: got %h expected 0", S_o); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_fixed(input logic [3:0] r, input int unsigned exp_lat, input string name);
        logic [319:0] s, exp;
        int unsigned lat;
        s = {5{64'hfeedfacecafebeef}};
        exp = model_perm(s, r);
        do_load(s, r);
        wait_done(lat);
        checks++;
        if (lat != exp_lat) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
        checks++;
        if (S_o !== exp) begin errors++; $display("FAIL %s_result: got %h expected %h", name, S_o, exp); end
        release_out();
        checks++;
        if ({in_ready_o, out_valid_o} !== 2'b10) begin
            errors++; $display("FAIL %s_release: got %b expected 10", name, {in_ready_o, out_valid_o});
        end
    endtask

    task automatic test_zero_and_clamp();
        int unsigned lat;
        logic [319:0] s, exp;
        do_load('1, 4'd0);
        wait_done(lat);
        checks++;
        if (lat != 0) begin errors++; $display("FAIL r0_latency: got %0d expected 0", lat); end
        checks++;
        if (S_o !== {320{1'b1}}) begin errors++; $display("FAIL r0_result: got %h expected all ones", S_o); end
        release_out();
        s = rand320();
        exp = model_perm(s, 12);
        do_load(s, 4'd15);
        wait_done(lat);
        checks++;
        if (lat != 12) begin errors++; $display("FAIL r15_latency: got %0d expected 12", lat); end
        checks++;
        if (S_o !== exp) begin errors++; $display("FAIL r15_result: got %h expected %h", S_o, exp); end
        release_out();
    endtask

    task automatic test_hold_and_ignore();
        logic [319:0] s, exp;
        int unsigned lat;
        s = rand320();
        exp = model_perm(s, 3);
        do_load(s, 4'd3);
        checks++;
        if ({busy_o, in_ready_o, out_valid_o} !== 3'b100) begin
            errors++; $display("FAIL run_flags: got %b expected 100", {busy_o, in_ready_o, out_valid_o});
        end
        in_valid_i = 1'b1; S_i = rand320(); rounds_i = 4'd0;
        wait_done(lat);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL hold_latency: got %0d expected 3", lat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (S_o !== exp || {out_valid_o, in_ready_o, busy_o} !== 3'b100) begin
                errors++;
                $display("FAIL hold_stable: cycle %0d flags %b expected 100 state %h expected %h",
                         i, {out_valid_o, in_ready_o, busy_o}, S_o, exp);
            end
        end
        in_valid_i = 1'b0;
        release_out();
        checks++;
        if ({in_ready_o, out_valid_o} !== 2'b10) begin
            errors++; $display("FAIL hold_release: got %b expected 10", {in_ready_o, out_valid_o});
        end
    endtask

    task automatic test_reset_mid_run();
        logic [319:0] s, exp;
        int unsigned lat;
        do_load(rand320(), 4'd12);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready_o, out_valid_o, busy_o} !== 3'b100 || S_o !== '0) begin
            errors++;
            $display("FAIL abort_reset: flags %b expected 100 state %h expected 0",
                     {in_ready_o, out_valid_o, busy_o}, S_o);
        end
        @(negedge clk); rst = 1'b0;
        s = rand320();
        exp = model_perm(s, 6);
        do_load(s, 4'd6);
        wait_done(lat);
        checks++;
        if (lat != 6) begin errors++; $display("FAIL after_abort_latency: got %0d expected 6", lat); end
        checks++;
        if (S_o !== exp) begin errors++; $display("FAIL after_abort_result: got %h expected %h", S_o, exp); end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [319:0] st [3];
        logic [319:0] exp [3];
        int unsigned n;
        logic want;
        for (int i = 0; i < 3; i++) begin st[i] = rand320(); exp[i] = model_perm(st[i], 12); end
        @(negedge clk);
        S_i = st[0]; rounds_i = 4'd12; in_valid_i = 1'b1; out_ready_i = 1'b1;
        @(posedge clk); #1;
        n = 0;
        for (int t = 0; t <= 44; t++) begin
            want = (t == 12 || t == 26 || t == 40);
            checks++;
            if (out_valid_o !== want) begin
                errors++; $display("FAIL b2b_valid: t=%0d got %b expected %b", t, out_valid_o, want);
            end
            if (want) begin
                checks++;
                if (S_o !== exp[n]) begin
                    errors++; $display("FAIL b2b_result%0d: got %h expected %h", n, S_o, exp[n]);
                end
                n++;
            end
            if (t == 0)  S_i = st[1];
            if (t == 14) S_i = st[2];
            if (t == 28) in_valid_i = 1'b0;
            @(posedge clk); #1;
        end
        out_ready_i = 1'b0;
    endtask

    task automatic test_random();
        logic [319:0] s, exp;
        logic [3:0] r;
        int unsigned lat, el;
        for (int i = 0; i < 8; i++) begin
            s = rand320();
            r = 4'($urandom_range(0, 15));
            exp = model_perm(s, r);
            el = (r > 12) ? 12 : r;
            do_load(s, r);
            out_ready_i = 1'($urandom);
            wait_done(lat);
            checks++;
            if (lat != el) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, el); end
            checks++;
            if (S_o !== exp) begin errors++; $display("FAIL rand%0d_result: got %h expected %h", i, S_o, exp); end
            out_ready_i = 1'b0;
            release_out();
            checks++;
            if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rand%0d_idle: got %b expected 1", i, in_ready_o); end
        end
    endtask

    initial begin
        test_reset();
        test_fixed(4'd12, 12, "p12");
        test_fixed(4'd8, 8, "p8");
        test_zero_and_clamp();
        test_hold_and_ignore();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
